// File: rtl/multiplication_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
//   state_t      : controller states IDLE / OP / DONE
//   DEFAULT_N    : default operand width
//   count_width(): width of the iteration counter for a given operand width
package multiplication_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_N = 32;

  // The counter holds N-1 at most, which always fits in $clog2(N) bits for N >= 2.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiplication.sv
// Sequential radix-2 shift-add unsigned multiplier, N x N -> 2N bits in N iterations.
// Shares the start/done handshake of the divider.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_ni       asynchronous active-low reset
//   start_i        request, sampled only while ready_o is high
//   multiplicand_i operand A, captured on the accepting edge
//   multiplier_i   operand B, captured on the accepting edge
//   ready_o        high in IDLE
//   done_o         one-cycle pulse when product_o becomes valid
//   product_o      A*B, stable from done_o until the next accepted start
//
// Build option: MULTIPLICATION_ZERO_SKIP_EN finishes in one cycle when either operand is zero.
module multiplication
  import multiplication_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [N-1:0]     multiplicand_i,
  input  logic [N-1:0]     multiplier_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [2*N-1:0]   product_o
);

  localparam int unsigned CW = count_width(N);

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [2*N-1:0]   p_q, p_d;
  logic [CW-1:0]    count_q, count_d;
  logic [N:0]       sum;

  // One N+1-bit adder: upper half of P plus the multiplicand when the current LSB is set.
  assign sum = {1'b0, p_q[2*N-1:N]} + {1'b0, (p_q[0] ? mcand_q : {N{1'b0}})};

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef MULTIPLICATION_ZERO_SKIP_EN
          if ((multiplicand_i == '0) || (multiplier_i == '0)) begin
            mcand_d = multiplicand_i;
            p_d     = '0;
            count_d = '0;
            state_d = DONE;
          end else begin
            mcand_d = multiplicand_i;
            p_d     = {{N{1'b0}}, multiplier_i};
            count_d = CW'(N - 1);
            state_d = OP;
          end
`else
          mcand_d = multiplicand_i;
          p_d     = {{N{1'b0}}, multiplier_i};
          count_d = CW'(N - 1);
          state_d = OP;
`endif
        end
      end
      OP: begin
        // Right shift with the adder carry entering the MSB.
        p_d = {sum, p_q[N-1:1]};
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    ready_o   = (state_q == IDLE);
    done_o    = (state_q == DONE);
    product_o = p_q;
  end

endmodule

// File: tb/tb_multiplication.sv
module tb_multiplication;

  localparam int N = 32;
`ifdef MULTIPLICATION_ZERO_SKIP_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           ready;
  logic           done;
  logic [2*N-1:0] product;

  int errors = 0;
  int checks = 0;

  multiplication #(.N(N)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .start_i        (start),
    .multiplicand_i (a),
    .multiplier_i   (b),
    .ready_o        (ready),
    .done_o         (done),
    .product_o      (product)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: edges elapsed since accept (-1 when idle) and the
  // number of edges until the product is announced.
  int          m_cyc = -1;
  int          m_lat = 0;
  logic [63:0] m_exp = '0;
  logic [63:0] m_last = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc  <= -1;
      m_last <= '0;
      m_exp  <= '0;
    end else if (m_cyc < 0) begin
      if (start) begin
        m_cyc <= 0;
        m_exp <= {32'b0, a} * {32'b0, b};
        m_lat <= (Skip && (a == 0 || b == 0)) ? 0 : N;
      end
    end else if (m_cyc == m_lat) begin
      m_cyc  <= -1;
      m_last <= m_exp;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    check64("ready", {63'b0, ready}, {63'b0, (m_cyc < 0)});
    check64("done", {63'b0, done}, {63'b0, (m_cyc >= 0 && m_cyc == m_lat)});
    if (m_cyc < 0) check64("product_idle", product, m_last);
    else if (m_cyc == m_lat) check64("product_done", product, m_exp);
  end

  task automatic wait_ready(input string name);
    int w = 0;
    while (!ready && w < 200) begin
      @(posedge clk); #2;
      w++;
    end
    if (!ready) check64({name, "_ready_timeout"}, 64'(w), 64'd0);
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [63:0] lit, input string name);
    int k;
    wait_ready(name);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check64({name, "_latency"}, 64'(k), (Skip && (x == 0 || y == 0)) ? 64'd0 : 64'(N));
    check64({name, "_product"}, product, lit);
  endtask

  initial begin
    int pulses;
    int last_done;
    // Reset with operands applied.
    reset_n = 1'b0;
    a = 32'h1234_5678;
    b = 32'h9abc_def0;
    repeat (3) @(posedge clk);
    #2;
    check64("rst_ready", {63'b0, ready}, 64'd1);
    check64("rst_done", {63'b0, done}, 64'd0);
    check64("rst_product", product, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;
    check64("rel_ready", {63'b0, ready}, 64'd1);
    check64("rel_product", product, 64'd0);

    run_op(32'd1000000, 32'd2000000, 64'h0000_01D1_A94A_2000, "big");
    run_op(32'd7, 32'd1, 64'd7, "seven");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
    run_op(32'd0, 32'd12345, 64'd0, "zero_a");
    run_op(32'd12345, 32'd0, 64'd0, "zero_b");

    // start held high: back-to-back operations, operands scrambled while busy.
    wait_ready("hold");
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    pulses = 0;
    last_done = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      if (done) begin
        check64("hold_product", product, 64'd15);
        if (last_done >= 0) check64("hold_interval", 64'(c - last_done), 64'(N + 2));
        last_done = c;
        pulses++;
      end
      if (ready) begin
        a = 32'd3;
        b = 32'd5;
      end else begin
        a = $urandom;
        b = $urandom;
      end
    end
    start = 1'b0;
    check64("hold_pulses", {63'b0, (pulses >= 2)}, 64'd1);

    // Reset in the middle of an operation.
    wait_ready("midrst");
    a = 32'd100;
    b = 32'd200;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check64("midrst_ready", {63'b0, ready}, 64'd1);
    check64("midrst_done", {63'b0, done}, 64'd0);
    check64("midrst_product", product, 64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (N + 4) @(posedge clk);
    #2;
    check64("midrst_after", product, 64'd0);
    run_op(32'd6, 32'd7, 64'd42, "six_seven");

    // Random traffic, including starts while busy and zero operands.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    end
    start = 1'b0;
    repeat (N + 5) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
